av_mailbox_slave: RTL and testbench
===================================

AV_MAILBOX_SLAVE -- requirements
Module: av_mailbox_slave

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning entries per FIFO; power of 2, range 2..16.
REQ-002 The block SHALL have port sysclk  in  1  sole clock; all state changes on its posedge.
REQ-003 The block SHALL have port sysreset  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have Avalon-MM slave ports: av_address in 2 (word select); av_read in 1; av_write in 1; av_writedata in 16; av_readdata out 16; av_waitrequest out 1.
REQ-005 The block SHALL have MCU-side Avalon-to-MCU (a2m) FIFO ports: mcu_rx_data out 16 (head word); mcu_rx_valid out 1 (a2m not empty); mcu_rx_pop in 1.
REQ-006 The block SHALL have MCU-side MCU-to-Avalon (m2a) FIFO ports: mcu_tx_data in 16; mcu_tx_push in 1; mcu_tx_full out 1.

Function
REQ-007 Register map SHALL be:
- 0 = m2a data (read pops);
- 1 = a2m data (write pushes);
- 2 = status;
- 3 = control.
REQ-008 Status SHALL read {underflow_sticky, 2'b0, m2a_count[4:0], 3'b0, a2m_count[4:0]}.
REQ-009 A status write SHALL clear underflow_sticky only when av_writedata[15]=1; all other status bits are read-only.
REQ-010 The FSM SHALL have states IDLE, STALL and ACK; av_waitrequest = (state != ACK).
REQ-011 IDLE SHALL transition on av_read or av_write (read wins if both are high): to ACK, except a write to address 1 while a2m is full goes to STALL.
REQ-012 STALL SHALL move to ACK in the cycle after a2m becomes non-full; it SHALL NOT time out.
REQ-013 ACK SHALL last exactly one cycle, then return to IDLE; a read therefore has one wait cycle, with av_waitrequest low in the 2nd cycle.
REQ-014 av_readdata SHALL be registered on IDLE->ACK, valid and stable for the whole ACK cycle, and held afterwards until the next read.
REQ-015 A read of address 0 SHALL pop m2a on the IDLE->ACK edge.
REQ-016 A read of address 0 while m2a is empty SHALL return 16'h0000, perform no pop, and set underflow_sticky.
REQ-017 An a2m push SHALL occur on the edge entering ACK.
REQ-018 Writes to address 0 SHALL be ignored but still acknowledged.
REQ-019 mcu_tx_push while m2a is full SHALL be dropped, with no state change.
REQ-020 mcu_rx_pop while a2m is empty SHALL be ignored.
REQ-021 A simultaneous push and pop on the same FIFO in one cycle SHALL leave the count unchanged and the data order preserved; this is valid when full if a pop is present.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL be 5-bit, range 0..DEPTH.
REQ-023 mcu_rx_data SHALL be the a2m head, combinationally valid when mcu_rx_valid=1.

Reset
REQ-024 On sysreset, asynchronously: FSM to IDLE; av_waitrequest=1; av_readdata=0; both FIFOs empty; mcu_rx_valid=0; mcu_tx_full=0; underflow_sticky=0; control=0.
REQ-025 Reset mid-transaction SHALL abort the transaction with no push or pop; the master retries after reset.

Configuration
REQ-026 With macro AV_MAILBOX_IRQ_EN defined: output port av_irq (1 bit) exists; control[0] is the irq enable (read/write); av_irq = control[0] && m2a non-empty, registered, reset 0.
REQ-027 Without AV_MAILBOX_IRQ_EN: there is no av_irq port, control reads 16'h0000, and writes to control are acknowledged but ignored.

Verification
REQ-028 MCU pushes 16'h1234 then 16'h5678; Avalon reads address 0 twice -> readdata 1234 then 5678, each after exactly 1 wait cycle; mcu_tx_full stays 0.
REQ-029 Avalon writes 8 words (DEPTH=8) to address 1, then a 9th of 16'hBEEF -> av_waitrequest stays high; after 3 cycles MCU pops once -> ACK the following cycle, BEEF lands at the tail, count=8.
REQ-030 Read address 0 while m2a is empty -> readdata 0000, status reads 16'h8000; write 16'h8000 to address 2 -> status 16'h0000.
REQ-031 Assert sysreset during STALL with a2m count=8 -> av_waitrequest=1 and count=0 immediately; after release a write to address 1 acks in 2 cycles.
REQ-032 With AV_MAILBOX_IRQ_EN: write control=1, MCU pushes one word -> av_irq=1 one cycle later; Avalon pops it -> av_irq=0 on the cycle after ACK.

Source files
------------

// File: rtl/av_mailbox_slave.sv
// Avalon-MM <-> MCU mailbox: two 16-bit FIFOs; Avalon accesses ack after one wait cycle, a2m writes stall while full.
// Optional av_irq output and control register enabled by defining AV_MAILBOX_IRQ_EN.

module av_mailbox_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [15:0] push_dat_i,
    input  logic        pop_i,
    output logic [15:0] head_dat_o,
    output logic [4:0]  count_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o    = (count_q == 5'd0);
    assign full_o     = (count_q == FULL_CNT);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 5'd1;
        else if (!do_push && do_pop) count_d = count_q - 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

module av_mailbox_slave #(
    parameter int DEPTH = 8
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [1:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
`ifdef AV_MAILBOX_IRQ_EN
    output logic        av_irq,
`endif
    output logic [15:0] mcu_rx_data,
    output logic        mcu_rx_valid,
    input  logic        mcu_rx_pop,
    input  logic [15:0] mcu_tx_data,
    input  logic        mcu_tx_push,
    output logic        mcu_tx_full
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] wdata_q, wdata_d;
    logic        sticky_q, sticky_d;
    logic        a2m_push, m2a_pop;
    logic [15:0] a2m_push_dat, m2a_head, status, ctrl_rd;
    logic [4:0]  a2m_count, m2a_count;
    logic        a2m_full, a2m_empty, m2a_empty;

    av_mailbox_fifo #(.DEPTH(DEPTH)) u_a2m (
        .clk        (sysclk),
        .rst        (sysreset),
        .push_i     (a2m_push),
        .push_dat_i (a2m_push_dat),
        .pop_i      (mcu_rx_pop),
        .head_dat_o (mcu_rx_data),
        .count_o    (a2m_count),
        .full_o     (a2m_full),
        .empty_o    (a2m_empty)
    );

    av_mailbox_fifo #(.DEPTH(DEPTH)) u_m2a (
        .clk        (sysclk),
        .rst        (sysreset),
        .push_i     (mcu_tx_push),
        .push_dat_i (mcu_tx_data),
        .pop_i      (m2a_pop),
        .head_dat_o (m2a_head),
        .count_o    (m2a_count),
        .full_o     (mcu_tx_full),
        .empty_o    (m2a_empty)
    );

    assign mcu_rx_valid   = !a2m_empty;
    assign av_waitrequest = (state_q != S_ACK);
    assign av_readdata    = rdata_q;
    assign status         = {sticky_q, 2'b00, m2a_count, 3'b000, a2m_count};

`ifdef AV_MAILBOX_IRQ_EN
    logic ctrl_q, ctrl_d, irq_q;
    assign ctrl_rd = {15'd0, ctrl_q};
    assign av_irq  = irq_q;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            ctrl_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= ctrl_q && !m2a_empty;
        end
    end
`else
    assign ctrl_rd = 16'h0000;
`endif

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        wdata_d      = wdata_q;
        sticky_d     = sticky_q;
        a2m_push     = 1'b0;
        a2m_push_dat = av_writedata;
        m2a_pop      = 1'b0;
`ifdef AV_MAILBOX_IRQ_EN
        ctrl_d       = ctrl_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (av_read) begin
                    state_d = S_ACK;
                    case (av_address)
                        2'd0: begin
                            if (m2a_empty) begin
                                rdata_d  = 16'h0000;
                                sticky_d = 1'b1;
                            end else begin
                                rdata_d = m2a_head;
                                m2a_pop = 1'b1;
                            end
                        end
                        2'd2:    rdata_d = status;
                        2'd3:    rdata_d = ctrl_rd;
                        default: rdata_d = 16'h0000;
                    endcase
                end else if (av_write) begin
                    state_d = S_ACK;
                    wdata_d = av_writedata;
                    case (av_address)
                        2'd1: begin
                            if (a2m_full) state_d  = S_STALL;
                            else          a2m_push = 1'b1;
                        end
                        2'd2: begin
                            if (av_writedata[15]) sticky_d = 1'b0;
                        end
                        2'd3: begin
`ifdef AV_MAILBOX_IRQ_EN
                            ctrl_d = av_writedata[0];
`endif
                        end
                        default: ;
                    endcase
                end
            end
            // Held write waits for the MCU to free a slot; no timeout.
            S_STALL: begin
                if (!a2m_full) begin
                    state_d      = S_ACK;
                    a2m_push     = 1'b1;
                    a2m_push_dat = wdata_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q  <= S_IDLE;
            rdata_q  <= 16'h0000;
            wdata_q  <= 16'h0000;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_av_mailbox_slave.sv
// Randomised self-checking bench for av_mailbox_slave against a queue-based mailbox model.
module tb_av_mailbox_slave;
    localparam int DEPTH = 8;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [1:0]  av_address;
    logic        av_read, av_write;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_waitrequest;
    logic [15:0] mcu_rx_data;
    logic        mcu_rx_valid, mcu_rx_pop;
    logic [15:0] mcu_tx_data;
    logic        mcu_tx_push, mcu_tx_full;
`ifdef AV_MAILBOX_IRQ_EN
    logic        av_irq;
`endif

    av_mailbox_slave #(.DEPTH(DEPTH)) dut (
        .sysclk         (sysclk),
        .sysreset       (sysreset),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
`ifdef AV_MAILBOX_IRQ_EN
        .av_irq         (av_irq),
`endif
        .mcu_rx_data    (mcu_rx_data),
        .mcu_rx_valid   (mcu_rx_valid),
        .mcu_rx_pop     (mcu_rx_pop),
        .mcu_tx_data    (mcu_tx_data),
        .mcu_tx_push    (mcu_tx_push),
        .mcu_tx_full    (mcu_tx_full)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    // Behavioural mailbox model
    logic [15:0] m2a_m[$];
    logic [15:0] a2m_m[$];
    bit          sticky_m = 1'b0;
    bit          ctrl_m   = 1'b0;

    function automatic logic [15:0] exp_status();
        return {sticky_m, 2'b00, 5'(m2a_m.size()), 3'b000, 5'(a2m_m.size())};
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] addr);
        logic [15:0] r;
        r = 16'h0000;
        case (addr)
            2'd0: begin
                if (m2a_m.size() == 0) sticky_m = 1'b1;
                else r = m2a_m.pop_front();
            end
            2'd2: r = exp_status();
            2'd3: r = {15'd0, ctrl_m};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic model_write(input logic [1:0] addr, input logic [15:0] d);
        if (addr == 2'd1 && a2m_m.size() < DEPTH) a2m_m.push_back(d);
        if (addr == 2'd2 && d[15]) sticky_m = 1'b0;
`ifdef AV_MAILBOX_IRQ_EN
        if (addr == 2'd3) ctrl_m = d[0];
`endif
    endtask

    // ack = index of the cycle (counting the request cycle as 1) in which waitrequest drops
    task automatic av_read_op(input logic [1:0] addr, output logic [15:0] d, output int ack);
        @(negedge sysclk);
        av_read = 1'b1; av_address = addr;
        ack = 1;
        do begin
            @(negedge sysclk);
            ack++;
        end while (av_waitrequest && ack < 64);
        d = av_readdata;
        av_read = 1'b0;
    endtask

    task automatic av_write_op(input logic [1:0] addr, input logic [15:0] d, output int ack);
        @(negedge sysclk);
        av_write = 1'b1; av_address = addr; av_writedata = d;
        ack = 1;
        do begin
            @(negedge sysclk);
            ack++;
        end while (av_waitrequest && ack < 64);
        av_write = 1'b0;
    endtask

    task automatic mcu_push(input logic [15:0] d);
        @(negedge sysclk);
        mcu_tx_push = 1'b1; mcu_tx_data = d;
        @(negedge sysclk);
        mcu_tx_push = 1'b0;
    endtask

    task automatic mcu_pop(output logic v, output logic [15:0] d);
        @(negedge sysclk);
        v = mcu_rx_valid; d = mcu_rx_data;
        mcu_rx_pop = 1'b1;
        @(negedge sysclk);
        mcu_rx_pop = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b exp=1", av_waitrequest); end
        total++; if (av_readdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", av_readdata); end
        total++; if (mcu_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", mcu_rx_valid); end
        total++; if (mcu_tx_full !== 1'b0) begin bad++; $display("FAIL rst_tx_full got=%b exp=0", mcu_tx_full); end
`ifdef AV_MAILBOX_IRQ_EN
        total++; if (av_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", av_irq); end
`endif
        @(negedge sysclk);
        sysreset = 1'b0;
        @(negedge sysclk);
        total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL idle_wait got=%b exp=1", av_waitrequest); end
    endtask

    task automatic test_basic();
        logic [15:0] d, e;
        int ack;
        mcu_push(16'h1234); m2a_m.push_back(16'h1234);
        mcu_push(16'h5678); m2a_m.push_back(16'h5678);
        for (int i = 0; i < 2; i++) begin
            av_read_op(2'd0, d, ack);
            e = model_read(2'd0);
            total++; if (d !== e) begin bad++; $display("FAIL basic_rdata got=%h exp=%h", d, e); end
            total++; if (ack !== 2) begin bad++; $display("FAIL basic_ack got=%0d exp=2", ack); end
            total++; if (mcu_tx_full !== 1'b0) begin bad++; $display("FAIL basic_tx_full got=%b exp=0", mcu_tx_full); end
        end
        // readdata must hold across a write
        av_write_op(2'd0, 16'hAAAA, ack);
        total++; if (av_readdata !== 16'h5678) begin bad++; $display("FAIL rdata_hold got=%h exp=5678", av_readdata); end
    endtask

    task automatic test_regs();
        logic [15:0] d, e;
        int ack;
        av_read_op(2'd0, d, ack);
        e = model_read(2'd0);
        total++; if (d !== 16'h0000 || d !== e) begin bad++; $display("FAIL underflow_rdata got=%h exp=0000", d); end
        av_read_op(2'd2, d, ack);
        total++; if (d !== 16'h8000) begin bad++; $display("FAIL status_sticky got=%h exp=8000", d); end
        av_write_op(2'd2, 16'h7FFF, ack); model_write(2'd2, 16'h7FFF);
        av_read_op(2'd2, d, ack);
        total++; if (d !== 16'h8000) begin bad++; $display("FAIL status_noclear got=%h exp=8000", d); end
        av_write_op(2'd2, 16'h8000, ack); model_write(2'd2, 16'h8000);
        total++; if (ack !== 2) begin bad++; $display("FAIL status_wr_ack got=%0d exp=2", ack); end
        av_read_op(2'd2, d, ack);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL status_clear got=%h exp=0000", d); end
        av_write_op(2'd3, 16'hFFFF, ack); model_write(2'd3, 16'hFFFF);
        av_read_op(2'd3, d, ack);
        e = model_read(2'd3);
        total++; if (d !== e) begin bad++; $display("FAIL ctrl_rd got=%h exp=%h", d, e); end
        av_write_op(2'd3, 16'h0000, ack); model_write(2'd3, 16'h0000);
        av_read_op(2'd1, d, ack);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL a2m_rd got=%h exp=0000", d); end
    endtask

    task automatic test_stall();
        logic [15:0] d, e;
        logic v;
        int ack;
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            av_write_op(2'd1, d, ack); model_write(2'd1, d);
            total++; if (ack !== 2) begin bad++; $display("FAIL fill_ack got=%0d exp=2", ack); end
        end
        @(negedge sysclk);
        av_write = 1'b1; av_address = 2'd1; av_writedata = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL stall_wait got=%b exp=1", av_waitrequest); end
        end
        total++; if (mcu_rx_data !== a2m_m[0]) begin bad++; $display("FAIL stall_head got=%h exp=%h", mcu_rx_data, a2m_m[0]); end
        mcu_rx_pop = 1'b1;
        @(negedge sysclk);
        mcu_rx_pop = 1'b0;
        void'(a2m_m.pop_front());
        total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL stall_release_early got=%b exp=1", av_waitrequest); end
        @(negedge sysclk);
        total++; if (av_waitrequest !== 1'b0) begin bad++; $display("FAIL stall_ack got=%b exp=0", av_waitrequest); end
        av_write = 1'b0;
        a2m_m.push_back(16'hBEEF);
        av_read_op(2'd2, d, ack);
        e = exp_status();
        total++; if (d !== e || d[4:0] !== 5'd8) begin bad++; $display("FAIL stall_status got=%h exp=%h", d, e); end
        while (a2m_m.size() > 0) begin
            mcu_pop(v, d);
            e = a2m_m.pop_front();
            total++; if (v !== 1'b1 || d !== e) begin bad++; $display("FAIL drain got=%b/%h exp=1/%h", v, d, e); end
        end
        mcu_pop(v, d);
        total++; if (v !== 1'b0) begin bad++; $display("FAIL empty_pop_valid got=%b exp=0", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, e;
        int ack;
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            av_write_op(2'd1, d, ack); model_write(2'd1, d);
        end
        mcu_push(16'hC0DE); m2a_m.push_back(16'hC0DE);
        @(negedge sysclk);
        av_write = 1'b1; av_address = 2'd1; av_writedata = 16'hDEAD;
        repeat (2) @(negedge sysclk);
        sysreset = 1'b1;
        #1;
        a2m_m.delete(); m2a_m.delete(); sticky_m = 1'b0; ctrl_m = 1'b0;
        total++; if (av_waitrequest !== 1'b1) begin bad++; $display("FAIL midrst_wait got=%b exp=1", av_waitrequest); end
        total++; if (mcu_rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid got=%b exp=0", mcu_rx_valid); end
        total++; if (av_readdata !== 16'h0000) begin bad++; $display("FAIL midrst_rdata got=%h exp=0000", av_readdata); end
        av_write = 1'b0;
        @(negedge sysclk);
        sysreset = 1'b0;
        av_write_op(2'd1, 16'h0F0F, ack); model_write(2'd1, 16'h0F0F);
        total++; if (ack !== 2) begin bad++; $display("FAIL retry_ack got=%0d exp=2", ack); end
        av_read_op(2'd2, d, ack);
        e = exp_status();
        total++; if (d !== e) begin bad++; $display("FAIL retry_status got=%h exp=%h", d, e); end
        total++; if (mcu_rx_data !== 16'h0F0F) begin bad++; $display("FAIL retry_head got=%h exp=0F0F", mcu_rx_data); end
    endtask

    task automatic test_full_simul();
        logic [15:0] d, e;
        int ack;
        while (m2a_m.size() < DEPTH) begin
            d = 16'($urandom);
            mcu_push(d); m2a_m.push_back(d);
        end
        total++; if (mcu_tx_full !== 1'b1) begin bad++; $display("FAIL tx_full got=%b exp=1", mcu_tx_full); end
        mcu_push(16'h5A5A);
        av_read_op(2'd2, d, ack);
        e = exp_status();
        total++; if (d !== e) begin bad++; $display("FAIL drop_status got=%h exp=%h", d, e); end
        // MCU push coincides with the Avalon pop edge on a full FIFO
        @(negedge sysclk);
        av_read = 1'b1; av_address = 2'd0; mcu_tx_push = 1'b1; mcu_tx_data = 16'hF00D;
        @(negedge sysclk);
        mcu_tx_push = 1'b0;
        e = model_read(2'd0);
        m2a_m.push_back(16'hF00D);
        total++; if (av_waitrequest !== 1'b0 || av_readdata !== e) begin bad++; $display("FAIL simul_rd got=%b/%h exp=0/%h", av_waitrequest, av_readdata, e); end
        av_read = 1'b0;
        @(negedge sysclk);
        total++; if (mcu_tx_full !== 1'b1) begin bad++; $display("FAIL simul_full got=%b exp=1", mcu_tx_full); end
        while (m2a_m.size() > 0) begin
            av_read_op(2'd0, d, ack);
            e = model_read(2'd0);
            total++; if (d !== e) begin bad++; $display("FAIL order got=%h exp=%h", d, e); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d, e;
        logic [1:0] a;
        logic v;
        int ack;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    d = 16'($urandom);
                    @(negedge sysclk);
                    total++; if (mcu_tx_full !== (m2a_m.size() == DEPTH)) begin bad++; $display("FAIL rnd_tx_full got=%b n=%0d", mcu_tx_full, m2a_m.size()); end
                    mcu_tx_push = 1'b1; mcu_tx_data = d;
                    @(negedge sysclk);
                    mcu_tx_push = 1'b0;
                    if (m2a_m.size() < DEPTH) m2a_m.push_back(d);
                end
                1: begin
                    mcu_pop(v, d);
                    total++; if (v !== (a2m_m.size() != 0)) begin bad++; $display("FAIL rnd_rx_valid got=%b n=%0d", v, a2m_m.size()); end
                    if (a2m_m.size() != 0) begin
                        e = a2m_m.pop_front();
                        total++; if (d !== e) begin bad++; $display("FAIL rnd_rx_data got=%h exp=%h", d, e); end
                    end
                end
                2, 4: begin
                    a = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
                    av_read_op(a, d, ack);
                    e = model_read(a);
                    total++; if (d !== e || ack !== 2) begin bad++; $display("FAIL rnd_read a=%0d got=%h/%0d exp=%h/2", a, d, ack, e); end
                end
                3: begin
                    d = 16'($urandom);
                    a = (a2m_m.size() < DEPTH) ? 2'd1 : 2'd0;
                    av_write_op(a, d, ack); model_write(a, d);
                    total++; if (ack !== 2) begin bad++; $display("FAIL rnd_wr_ack got=%0d exp=2", ack); end
                end
                default: begin
                    d = 16'($urandom);
                    av_write_op(2'd2, d, ack); model_write(2'd2, d);
                    total++; if (ack !== 2) begin bad++; $display("FAIL rnd_st_ack got=%0d exp=2", ack); end
                end
            endcase
        end
    endtask

`ifdef AV_MAILBOX_IRQ_EN
    task automatic test_irq();
        logic [15:0] d, e;
        int ack;
        while (m2a_m.size() > 0) begin
            av_read_op(2'd0, d, ack);
            e = model_read(2'd0);
            total++; if (d !== e) begin bad++; $display("FAIL irq_drain got=%h exp=%h", d, e); end
        end
        av_write_op(2'd3, 16'h0001, ack); model_write(2'd3, 16'h0001);
        mcu_push(16'h4242); m2a_m.push_back(16'h4242);
        total++; if (av_irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", av_irq); end
        @(negedge sysclk);
        total++; if (av_irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", av_irq); end
        av_read_op(2'd0, d, ack);
        e = model_read(2'd0);
        total++; if (d !== e || av_irq !== 1'b1) begin bad++; $display("FAIL irq_ack got=%h/%b exp=%h/1", d, av_irq, e); end
        @(negedge sysclk);
        total++; if (av_irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", av_irq); end
    endtask
`endif

    initial begin
        sysreset = 1'b1;
        av_address = 2'd0; av_read = 1'b0; av_write = 1'b0; av_writedata = 16'h0000;
        mcu_rx_pop = 1'b0; mcu_tx_push = 1'b0; mcu_tx_data = 16'h0000;
        test_reset();
        test_basic();
        test_regs();
        test_stall();
        test_reset_mid();
        test_full_simul();
        test_random();
`ifdef AV_MAILBOX_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
